// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (read only) and a data port (read/write).
// Three-state FSM (IDLE -> ACC -> DONE). All outputs are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie, grant the requester not served last
//   undefined -> fixed priority, data over fetch (no pointer state)
// Handshake: a requester holds req (plus address/data) until it sees its
// gnt pulse. gnt is high for exactly the first ACC cycle. rvalid pulses for
// one cycle in DONE; rsp_data is valid then for reads and is held until the
// next read capture.
module mem_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] rsp_data,
   output logic [31:0] mem_addr,
   output logic        mem_write_en,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_data,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   generate
      if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
         $error("mem_arbiter: MEM_LAT must be in 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;      // 1 = data port owns the transaction
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        if_gnt_q, if_gnt_d;
   logic        if_rvalid_q, if_rvalid_d;
   logic        d_gnt_q, d_gnt_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_write_en_q, mem_write_en_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;
   logic        busy_q, busy_d;

   logic        pick_data;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data served last; reset value 0 means "fetch served last".
   logic last_data_q, last_data_d;

   // Round robin: on a tie the port not served last wins.
   always_comb begin
      pick_data = d_req;
      if (if_req && d_req) begin
         pick_data = !last_data_q;
      end
   end
`else
   // Fixed priority: data always beats fetch.
   always_comb begin
      pick_data = d_req;
   end
`endif

   // Next-state and next-output logic for the arbiter FSM.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      owner_d          = owner_q;
      we_d             = we_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      rsp_data_d       = rsp_data_q;
      if_gnt_d         = 1'b0;
      if_rvalid_d      = 1'b0;
      d_gnt_d          = 1'b0;
      d_rvalid_d       = 1'b0;
      mem_addr_d       = 32'h0;
      mem_write_en_d   = 1'b0;
      mem_write_data_d = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_d      = last_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               state_d  = ACC;
               cnt_d    = 3'd0;
               owner_d  = pick_data;
               // Fetches are always reads.
               we_d     = pick_data && d_we;
               addr_d   = pick_data ? d_addr : if_addr;
               wdata_d  = pick_data ? d_wdata : 32'h0;
               if_gnt_d = !pick_data;
               d_gnt_d  = pick_data;
               // Memory signals must be live in the first ACC cycle.
               mem_addr_d       = addr_d;
               mem_write_en_d   = we_d;
               mem_write_data_d = we_d ? wdata_d : 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
               last_data_d = pick_data;
`endif
            end
         end
         ACC: begin
            if (we_q || cnt_q == LAST_CNT) begin
               // Write finishes after one cycle; read captures on its last cycle.
               if (!we_q) begin
                  rsp_data_d = mem_data;
               end
               state_d     = DONE;
               cnt_d       = 3'd0;
               if_rvalid_d = !owner_q;
               d_rvalid_d  = owner_q;
            end else begin
               cnt_d      = cnt_q + 3'd1;
               mem_addr_d = addr_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, latches and registered outputs; reset drops any transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         cnt_q            <= 3'd0;
         owner_q          <= 1'b0;
         we_q             <= 1'b0;
         addr_q           <= 32'h0;
         wdata_q          <= 32'h0;
         rsp_data_q       <= 32'h0;
         if_gnt_q         <= 1'b0;
         if_rvalid_q      <= 1'b0;
         d_gnt_q          <= 1'b0;
         d_rvalid_q       <= 1'b0;
         mem_addr_q       <= 32'h0;
         mem_write_en_q   <= 1'b0;
         mem_write_data_q <= 32'h0;
         busy_q           <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q      <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         owner_q          <= owner_d;
         we_q             <= we_d;
         addr_q           <= addr_d;
         wdata_q          <= wdata_d;
         rsp_data_q       <= rsp_data_d;
         if_gnt_q         <= if_gnt_d;
         if_rvalid_q      <= if_rvalid_d;
         d_gnt_q          <= d_gnt_d;
         d_rvalid_q       <= d_rvalid_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_write_data_q <= mem_write_data_d;
         busy_q           <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q      <= last_data_d;
`endif
      end
   end

   assign if_gnt         = if_gnt_q;
   assign if_rvalid      = if_rvalid_q;
   assign d_gnt          = d_gnt_q;
   assign d_rvalid       = d_rvalid_q;
   assign rsp_data       = rsp_data_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_write_data = mem_write_data_q;
   assign busy           = busy_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table on a MEM_LAT=2 instance, plus
// hand-written sequences for arbitration order and reset mid-transaction
// on a MEM_LAT=4 instance. Both instances share all inputs.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] mem_data;

   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en, busy;
   logic [31:0] rsp_data, mem_addr, mem_write_data;
   logic [1:0]  dbg_state;

   logic        if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, mem_write_en4, busy4;
   logic [31:0] rsp_data4, mem_addr4, mem_write_data4;
   logic [1:0]  dbg_state4;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.MEM_LAT(2)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rsp_data(rsp_data),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_data(mem_data),
      .busy(busy), .dbg_state(dbg_state)
   );

   mem_arbiter #(.MEM_LAT(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt4), .if_rvalid(if_rvalid4),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .rsp_data(rsp_data4),
      .mem_addr(mem_addr4), .mem_write_en(mem_write_en4),
      .mem_write_data(mem_write_data4), .mem_data(mem_data),
      .busy(busy4), .dbg_state(dbg_state4)
   );

   // {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en, busy, rsp, maddr, mwdata}
   logic [101:0] act_vec, act_vec4;
   assign act_vec  = {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en, busy,
                      rsp_data, mem_addr, mem_write_data};
   assign act_vec4 = {if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, mem_write_en4, busy4,
                      rsp_data4, mem_addr4, mem_write_data4};

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [31:0] md;
      logic [5:0]  flags;
      logic [31:0] rsp;
      logic [31:0] maddr;
      logic [31:0] mwd;
   } vec_t;

   vec_t vecs[$];
   logic exp_q[$];   // expected grant order, 1 = data

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [101:0] act, input logic [101:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic ir, input logic [31:0] ia, input logic dr,
                          input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                          input logic [31:0] md, input logic [5:0] flags,
                          input logic [31:0] rsp, input logic [31:0] maddr,
                          input logic [31:0] mwd);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.md = md; v.flags = flags; v.rsp = rsp; v.maddr = maddr; v.mwd = mwd;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int grants;
      int quiet_err;
      int lat;
      logic got;

      reset = 1'b1;
      mem_data = 32'h0;
      idle_inputs();

      // Flags: {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en, busy}
      // Fetch read, MEM_LAT=2
      add_vec(1, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF, 6'b100001, 32'h0,        32'h100, 0);
      add_vec(0, 0,       0, 0, 0, 0, 32'hDEADBEEF, 6'b000001, 32'h0,        32'h100, 0);
      add_vec(0, 0,       0, 0, 0, 0, 32'hDEADBEEF, 6'b010001, 32'hDEADBEEF, 32'h0,   0);
      add_vec(0, 0,       0, 0, 0, 0, 32'hDEADBEEF, 6'b000000, 32'hDEADBEEF, 32'h0,   0);
      // Data write: one ACC cycle, rsp_data untouched
      add_vec(0, 0, 1, 1, 32'h40, 32'h12345678, 32'h55555555, 6'b001011, 32'hDEADBEEF, 32'h40, 32'h12345678);
      add_vec(0, 0, 0, 0, 0,      0,            32'h55555555, 6'b000101, 32'hDEADBEEF, 32'h0,  0);
      add_vec(0, 0, 0, 0, 0,      0,            32'h55555555, 6'b000000, 32'hDEADBEEF, 32'h0,  0);
      // Data read
      add_vec(0, 0, 1, 0, 32'h80, 0, 32'hCAFEF00D, 6'b001001, 32'hDEADBEEF, 32'h80, 0);
      add_vec(0, 0, 0, 0, 0,      0, 32'hCAFEF00D, 6'b000001, 32'hDEADBEEF, 32'h80, 0);
      add_vec(0, 0, 0, 0, 0,      0, 32'hCAFEF00D, 6'b000101, 32'hCAFEF00D, 32'h0,  0);
      add_vec(0, 0, 0, 0, 0,      0, 32'hCAFEF00D, 6'b000000, 32'hCAFEF00D, 32'h0,  0);
      // First tie after reset goes to data; fetch stays pending
      add_vec(1, 32'h200, 1, 0, 32'h300, 0, 32'h11111111, 6'b001001, 32'hCAFEF00D, 32'h300, 0);
      add_vec(1, 32'h200, 0, 0, 0,       0, 32'h11111111, 6'b000001, 32'hCAFEF00D, 32'h300, 0);
      add_vec(1, 32'h200, 0, 0, 0,       0, 32'h11111111, 6'b000101, 32'h11111111, 32'h0,   0);
      add_vec(1, 32'h200, 0, 0, 0,       0, 32'h11111111, 6'b000000, 32'h11111111, 32'h0,   0);
      add_vec(1, 32'h200, 0, 0, 0,       0, 32'h11111111, 6'b100001, 32'h11111111, 32'h200, 0);
      add_vec(0, 0,       0, 0, 0,       0, 32'h22222222, 6'b000001, 32'h11111111, 32'h200, 0);
      add_vec(0, 0,       0, 0, 0,       0, 32'h22222222, 6'b010001, 32'h22222222, 32'h0,   0);
      add_vec(0, 0,       0, 0, 0,       0, 32'h22222222, 6'b000000, 32'h22222222, 32'h0,   0);
      // Write attributes without a request do nothing
      add_vec(0, 0, 0, 1, 32'h44, 32'hFFFF0000, 32'h33333333, 6'b000000, 32'h22222222, 32'h0, 0);

      // Reset state
      #2;
      check("reset_outputs", act_vec, 102'h0);
      check("reset_outputs_lat4", act_vec4, 102'h0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven cycles on the MEM_LAT=2 instance
      for (int i = 0; i < vecs.size(); i++) begin
         if_req = vecs[i].ir; if_addr = vecs[i].ia;
         d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
         d_wdata = vecs[i].dwd; mem_data = vecs[i].md;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), act_vec,
               {vecs[i].flags, vecs[i].rsp, vecs[i].maddr, vecs[i].mwd});
      end

      // Arbitration order with both requests held high
      pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
      grants = 0;
      for (int c = 0; c < 60 && grants < 4; c++) begin
         @(negedge clk);
         if (if_gnt || d_gnt) begin
            got = d_gnt;
            grants++;
            check($sformatf("grant%0d", grants), {101'h0, got}, {101'h0, exp_q.pop_front()});
         end
      end
      check("grant_count", 102'(grants), 102'd4);
      idle_inputs();

      // Reset in the second ACC cycle of a MEM_LAT=4 read
      pulse_reset();
      if_req = 1'b1; if_addr = 32'h500; mem_data = 32'hABCD0001;
      @(posedge clk);
      @(negedge clk);
      check("lat4_gnt", {101'h0, if_gnt4}, {101'h0, 1'b1});
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("lat4_reset_outputs", act_vec4, 102'h0);
      check("lat4_reset_state", {100'h0, dbg_state4}, 102'h0);
      @(negedge clk);
      reset = 1'b0;
      quiet_err = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (if_gnt4 || if_rvalid4 || d_gnt4 || d_rvalid4 || mem_write_en4 || busy4)
            quiet_err++;
      end
      check("lat4_no_activity_after_reset", 102'(quiet_err), 102'd0);

      // Next request after reset completes normally: gnt at 1, rvalid at 5
      if_req = 1'b1; if_addr = 32'h600; mem_data = 32'h0BADF00D;
      @(posedge clk);
      @(negedge clk);
      check("lat4_next_gnt", {act_vec4[101], act_vec4[63:32]}, {1'b1, 32'h600});
      idle_inputs();
      lat = 0;
      for (int c = 2; c < 20 && lat == 0; c++) begin
         @(negedge clk);
         if (if_rvalid4) lat = c;
      end
      check("lat4_rvalid_cycle", 102'(lat), 102'd5);
      check("lat4_rsp_data", {70'h0, rsp_data4}, {70'h0, 32'h0BADF00D});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4; any other value SHALL fail elaboration.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-005 if_addr  input  32  fetch address; sampled on the accept edge.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 if_rvalid  output  1  one-cycle pulse: rsp_data holds fetch data.
REQ-008 d_req  input  1  data request; held until d_gnt.
REQ-009 d_we  input  1  data write when 1, read when 0; sampled with d_req.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  data write value.
REQ-012 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-013 d_rvalid  output  1  one-cycle pulse: data transaction complete; rsp_data valid for reads.
REQ-014 rsp_data  output  32  registered read data, shared by both requesters.
REQ-015 mem_addr  output  32  single-port memory address.
REQ-016 mem_write_en  output  1  memory write strobe.
REQ-017 mem_write_data  output  32  memory write value.
REQ-018 mem_data  input  32  memory read data, valid MEM_LAT cycles after mem_addr is first driven.
REQ-019 busy  output  1  1 whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-021 IDLE: on an edge with any request, select the winner; latch owner, address, we and wdata; go to ACC. With no request, stay in IDLE.
REQ-022 The winner's gnt SHALL be high for exactly the first ACC cycle; the loser's gnt SHALL stay 0, and its request SHALL remain pending.
REQ-023 ACC, read: drive mem_addr from the latch for MEM_LAT cycles using a 3-bit counter; on the last ACC edge, capture mem_data into rsp_data; go to DONE.
REQ-024 ACC, write: lasts exactly 1 cycle, with mem_write_en=1 and mem_write_data=latched wdata; rsp_data is unchanged; go to DONE.
REQ-025 DONE: pulse the owner's rvalid for 1 cycle, then go to IDLE.
REQ-026 Latency: accept edge at cycle 0 -> gnt in cycle 1 -> read rvalid in cycle MEM_LAT+1, write rvalid in cycle 2.
REQ-027 Minimum spacing of back-to-back transactions is one IDLE cycle.
REQ-028 Fetch requests SHALL always be reads.
REQ-029 In IDLE and DONE, mem_addr, mem_write_en and mem_write_data SHALL be 0.
REQ-030 rsp_data SHALL hold its value until the next read capture.
REQ-031 Request changes during ACC or DONE SHALL be ignored until the next IDLE.

Reset
REQ-032 When reset is asserted, the block SHALL asynchronously go to IDLE and clear the counter, the latches and rsp_data.
REQ-033 When reset is asserted, every output SHALL be driven to 0, and the round-robin pointer SHALL be set to "fetch served last".
REQ-034 Reset during ACC or DONE SHALL drop the transaction: no gnt, rvalid or write strobe after reset.
REQ-035 The first accept edge after reset deassertion SHALL be the first rising edge that sees reset=0.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not served last; the pointer updates on every accept.
REQ-037 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority with data over fetch; no pointer state.
REQ-038 In both modes, the first tie after reset SHALL go to data.

Verification
REQ-039 MEM_LAT=2, if_req=1, if_addr=0x100, mem_data=0xDEADBEEF -> if_gnt pulses in cycle 1; mem_addr=0x100 in cycles 1-2; if_rvalid in cycle 3 with rsp_data=0xDEADBEEF.
REQ-040 d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_write_en=1 for exactly cycle 1 with those values; d_rvalid in cycle 2; rsp_data unchanged.
REQ-041 Fixed priority, if_req and d_req held high for 3 transactions -> grant order d, d, d; fetch starves.
REQ-042 ARB_ROUND_ROBIN_EN defined, both requests held high -> grant order d, if, d, if.
REQ-043 MEM_LAT=4, reset pulsed in the second ACC cycle of a read -> all outputs 0 immediately; no rvalid; busy=0; the next request completes normally.
